uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
Parametrised baud-rate generator for the UART TX/RX paths; successor to the fixed-ratio UART clock divider. It produces single-cycle clock enables in the clk_i domain instead of a divided clock, so no BUFG and no new clock domain. Both divisors are runtime-programmable with fractional resolution. Outputs are an oversample tick, a bit tick and a mid-bit sample tick, plus an RX phase-resync input for start-bit alignment.

Parameters:
CLK_HZ, 100_000_000, clk_i frequency in Hz
DEFAULT_BAUD, 115200, baud rate after reset
OVS, 16, oversample ticks per bit; even, >= 4
DIV_W, 16, width of integer divisor
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clk)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-low
en_i  in  1  generator enable
cfg_valid_i  in  1  new divisor offered
cfg_ready_o  out  1  divisor can be accepted
div_int_i  in  DIV_W  integer oversample period in clk cycles, >= 2
div_frac_i  in  FRAC_W  fractional oversample period
cfg_err_o  out  1  one-cycle pulse: offered div_int_i < 2, rejected
os_tick_o  out  1  oversample enable pulse
mid_tick_o  out  1  mid-bit sample pulse
bit_tick_o  out  1  bit-boundary pulse
os_cnt_o  out  $clog2(OVS)  oversample phase index

Behaviour:
- Reset: DEFAULT_INT = floor(CLK_HZ*2^FRAC_W/(DEFAULT_BAUD*OVS)) >> FRAC_W; DEFAULT_FRAC = the same value mod 2^FRAC_W. At 100 MHz/115200/16 this gives 868, so int 54 and frac 4.
- Reset values: active divisor = defaults; acc = 0; os_cnt_o = 0; all ticks = 0; cfg_err_o = 0; cfg_ready_o = 1; no pending config.
- Period: each oversample period lasts div_int cycles, or div_int+1 cycles when the fractional add carries. On every os_tick, acc <= (acc + frac) mod 2^FRAC_W. A carry out of that add lengthens the next period by 1 cycle.
- Enable: while en_i = 0, the counter holds at the start of a period, acc = 0, os_cnt_o = 0, and all ticks are 0. The first os_tick_o occurs exactly div_int cycles after the first edge that samples en_i = 1.
- os_cnt_o increments on each os_tick, modulo OVS.
- mid_tick_o coincides with the os_tick that moves os_cnt_o from OVS/2-1 to OVS/2.
- bit_tick_o coincides with the os_tick that moves os_cnt_o from OVS-1 to 0.
- All tick outputs are registered, one cycle wide, and never asserted on consecutive cycles.
- Config handshake: a transfer occurs when cfg_valid_i && cfg_ready_o.
  - If div_int_i < 2: pulse cfg_err_o the next cycle; active and pending config unchanged; cfg_ready_o stays 1.
  - Otherwise: the value becomes pending and cfg_ready_o drops.
- Applying a pending config:
  - It is applied at the next os_tick; the period starting after that tick uses the new values, and acc is cleared.
  - It is applied immediately (next cycle) if en_i = 0.
  - It is also applied on rx_resync_i.
  - cfg_ready_o returns to 1 the cycle after apply.
- rx_resync_i (one-cycle pulse): next cycle, the counter restarts a full period, acc = 0, and os_cnt_o = 0. Any tick that would have fired in the resync cycle is suppressed. The next mid_tick_o therefore comes OVS/2 oversample periods after resync.
- Priority: rst_i > en_i = 0 > rx_resync_i > normal counting. A resync while en_i = 0 has no effect beyond the hold state.
- Reset mid-operation: all state returns to reset values asynchronously, and any pending config is discarded.

Test Plan:
- Defaults at 100 MHz, en_i = 1 -> os_tick spacing repeats 54, 54, 54, 55; bit_tick spacing exactly 868 cycles; mid_tick 434 cycles after each bit_tick (every 8 os_ticks, 3x54+1x55 pattern).
- Config div_int = 3, div_frac = 0 with en_i = 0, then enable -> first os_tick 3 cycles after enable; bit_tick every 48 cycles; os_cnt_o runs 0..15; cfg_ready_o high again 1 cycle after accept.
- Config div_int = 1 -> cfg_err_o high for 1 cycle; tick spacing unchanged (54/55 pattern); cfg_ready_o stays 1.
- Config accepted mid-period while running -> old spacing until the next os_tick, new spacing from then on; cfg_ready_o low between accept and apply.
- rx_resync_i pulsed in the same cycle a tick is due -> no tick that cycle; os_cnt_o = 0; mid_tick_o exactly 8*div_int cycles later (frac = 0 case).
- rst_i asserted mid-bit with a pending config -> outputs 0 immediately; after release, default config and cfg_ready_o = 1.

Source files
------------

// File: rtl/uart_baud_gen.sv
// Fractional-N baud-rate generator: emits oversample, mid-bit and bit-boundary
// clock enables in the clk_i domain with a runtime-programmable divisor.
module uart_baud_gen #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned DEFAULT_BAUD = 115200,
   parameter int unsigned OVS          = 16,
   parameter int unsigned DIV_W        = 16,
   parameter int unsigned FRAC_W       = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_i,
   input  logic                   cfg_valid_i,
   output logic                   cfg_ready_o,
   input  logic [DIV_W-1:0]       div_int_i,
   input  logic [FRAC_W-1:0]      div_frac_i,
   output logic                   cfg_err_o,
   input  logic                   rx_resync_i,
   output logic                   os_tick_o,
   output logic                   mid_tick_o,
   output logic                   bit_tick_o,
   output logic [$clog2(OVS)-1:0] os_cnt_o
);

   localparam int unsigned OC_W  = $clog2(OVS);
   localparam int unsigned CNT_W = DIV_W + 1;
   localparam logic [63:0] DEF_FULL =
      (64'(CLK_HZ) << FRAC_W) / (64'(DEFAULT_BAUD) * 64'(OVS));
   localparam logic [DIV_W-1:0]  DEF_INT    = DIV_W'(DEF_FULL >> FRAC_W);
   localparam logic [FRAC_W-1:0] DEF_FRAC   = FRAC_W'(DEF_FULL);
   localparam logic [OC_W-1:0]   OC_MID_PRE = OC_W'(OVS / 2 - 1);
   localparam logic [OC_W-1:0]   OC_LAST    = OC_W'(OVS - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              extra_q, extra_d;
   logic [OC_W-1:0]   os_cnt_q, os_cnt_d;
   logic [DIV_W-1:0]  div_int_q, div_int_d;
   logic [FRAC_W-1:0] div_frac_q, div_frac_d;
   logic              pend_q, pend_d;
   logic [DIV_W-1:0]  pend_int_q, pend_int_d;
   logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
   logic              os_tick_q, os_tick_d;
   logic              mid_tick_q, mid_tick_d;
   logic              bit_tick_q, bit_tick_d;
   logic              cfg_err_q, cfg_err_d;

   logic [CNT_W-1:0]  period;
   logic              due;
   logic              apply;
   logic [FRAC_W:0]   frac_sum;

   // cnt_q runs 1..period while counting; 0 only in the disabled hold state,
   // so the edge that first samples en_i high counts as cycle 1 of the period.
   assign period = CNT_W'(div_int_q) + CNT_W'(extra_q);
   assign due    = (cnt_q == period);

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      extra_d     = extra_q;
      os_cnt_d    = os_cnt_q;
      div_int_d   = div_int_q;
      div_frac_d  = div_frac_q;
      pend_d      = pend_q;
      pend_int_d  = pend_int_q;
      pend_frac_d = pend_frac_q;
      os_tick_d   = 1'b0;
      mid_tick_d  = 1'b0;
      bit_tick_d  = 1'b0;
      cfg_err_d   = 1'b0;
      apply       = 1'b0;
      frac_sum    = {1'b0, acc_q} + {1'b0, div_frac_q};

      if (!en_i || rx_resync_i) begin
         // Resync restarts a full period immediately; disable parks before it.
         cnt_d    = en_i ? CNT_W'(1) : '0;
         acc_d    = '0;
         extra_d  = 1'b0;
         os_cnt_d = '0;
         apply    = pend_q;
      end else if (due) begin
         cnt_d      = CNT_W'(1);
         os_tick_d  = 1'b1;
         mid_tick_d = (os_cnt_q == OC_MID_PRE);
         bit_tick_d = (os_cnt_q == OC_LAST);
         os_cnt_d   = (os_cnt_q == OC_LAST) ? '0 : os_cnt_q + OC_W'(1);
         acc_d      = frac_sum[FRAC_W-1:0];
         extra_d    = frac_sum[FRAC_W];
         if (pend_q) begin
            apply   = 1'b1;
            acc_d   = '0;
            extra_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (apply) begin
         div_int_d  = pend_int_q;
         div_frac_d = pend_frac_q;
         pend_d     = 1'b0;
      end

      // Only one divisor may be in flight; ready is simply "nothing pending".
      if (cfg_valid_i && !pend_q) begin
         if (div_int_i < DIV_W'(2)) begin
            cfg_err_d = 1'b1;
         end else begin
            pend_d      = 1'b1;
            pend_int_d  = div_int_i;
            pend_frac_d = div_frac_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         extra_q     <= 1'b0;
         os_cnt_q    <= '0;
         div_int_q   <= DEF_INT;
         div_frac_q  <= DEF_FRAC;
         pend_q      <= 1'b0;
         pend_int_q  <= '0;
         pend_frac_q <= '0;
         os_tick_q   <= 1'b0;
         mid_tick_q  <= 1'b0;
         bit_tick_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         extra_q     <= extra_d;
         os_cnt_q    <= os_cnt_d;
         div_int_q   <= div_int_d;
         div_frac_q  <= div_frac_d;
         pend_q      <= pend_d;
         pend_int_q  <= pend_int_d;
         pend_frac_q <= pend_frac_d;
         os_tick_q   <= os_tick_d;
         mid_tick_q  <= mid_tick_d;
         bit_tick_q  <= bit_tick_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign cfg_ready_o = !pend_q;
   assign cfg_err_o   = cfg_err_q;
   assign os_tick_o   = os_tick_q;
   assign mid_tick_o  = mid_tick_q;
   assign bit_tick_o  = bit_tick_q;
   assign os_cnt_o    = os_cnt_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Testbench for uart_baud_gen: directed and random stimulus compared each cycle
// against a deadline-based reference model of the tick schedule.
module tb_uart_baud_gen;

   localparam int CLK_HZ = 100_000_000;
   localparam int BAUD   = 115200;
   localparam int OVS    = 16;
   localparam int DIV_W  = 16;
   localparam int FRAC_W = 4;
   localparam int CW     = $clog2(OVS);
   localparam int FMOD   = 1 << FRAC_W;

   logic              clk = 1'b0;
   logic              rst_i, en_i, cfg_valid_i, rx_resync_i;
   logic [DIV_W-1:0]  div_int_i;
   logic [FRAC_W-1:0] div_frac_i;
   logic              cfg_ready_o, cfg_err_o, os_tick_o, mid_tick_o, bit_tick_o;
   logic [CW-1:0]     os_cnt_o;

   uart_baud_gen #(
      .CLK_HZ(CLK_HZ), .DEFAULT_BAUD(BAUD), .OVS(OVS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .div_int_i(div_int_i), .div_frac_i(div_frac_i), .cfg_err_o(cfg_err_o),
      .rx_resync_i(rx_resync_i),
      .os_tick_o(os_tick_o), .mid_tick_o(mid_tick_o), .bit_tick_o(bit_tick_o),
      .os_cnt_o(os_cnt_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n     = 0;   // number of rising edges seen so far

   // Reference model: absolute edge number of the next due tick plus config.
   int m_int, m_frac, m_acc, m_os, m_pint, m_pfrac, m_next;
   bit m_pend;
   bit e_os, e_mid, e_bit, e_err;
   int def_int, def_frac;

   // Observation trackers for spacing checks.
   int last_os, last_bit, last_mid, bit_gap, mid_bit, os_gap_min, os_gap_max;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s at edge %0d: observed %0h, expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_int  = def_int;
      m_frac = def_frac;
      m_acc  = 0;
      m_os   = 0;
      m_pend = 0;
      e_os = 0; e_mid = 0; e_bit = 0; e_err = 0;
      m_next = n + 1 + m_int;
   endtask

   task automatic model_edge();
      bit xfer;
      int s, carry;
      e_os = 0; e_mid = 0; e_bit = 0; e_err = 0;
      if (!rst_i) begin
         model_reset();
         return;
      end
      xfer = cfg_valid_i && !m_pend;
      if (!en_i || rx_resync_i) begin
         if (m_pend) begin
            m_int = m_pint; m_frac = m_pfrac; m_pend = 0;
         end
         m_acc  = 0;
         m_os   = 0;
         m_next = en_i ? n + m_int : n + 1 + m_int;
      end else if (n == m_next) begin
         e_os  = 1;
         e_mid = (m_os == OVS / 2 - 1);
         e_bit = (m_os == OVS - 1);
         m_os  = (m_os + 1) % OVS;
         if (m_pend) begin
            m_int = m_pint; m_frac = m_pfrac; m_pend = 0;
            m_acc = 0; carry = 0;
         end else begin
            s     = m_acc + m_frac;
            carry = s / FMOD;
            m_acc = s % FMOD;
         end
         m_next = n + m_int + carry;
      end
      if (xfer) begin
         if (int'(div_int_i) < 2) e_err = 1;
         else begin
            m_pend = 1; m_pint = int'(div_int_i); m_pfrac = int'(div_frac_i);
         end
      end
   endtask

   task automatic check_outputs();
      logic [31:0] obs, exp;
      obs = 32'({os_tick_o, mid_tick_o, bit_tick_o, cfg_err_o, cfg_ready_o, os_cnt_o});
      exp = 32'({e_os, e_mid, e_bit, e_err, !m_pend, CW'(m_os)});
      chk("cycle{os,mid,bit,err,rdy,cnt}", obs, exp);
   endtask

   task automatic meas_reset();
      last_os = -1; last_bit = -1; last_mid = -1;
      bit_gap = -1; mid_bit = -1;
      os_gap_min = 1_000_000; os_gap_max = 0;
   endtask

   task automatic track();
      if (os_tick_o) begin
         if (last_os >= 0) begin
            if (n - last_os < os_gap_min) os_gap_min = n - last_os;
            if (n - last_os > os_gap_max) os_gap_max = n - last_os;
         end
         last_os = n;
      end
      if (mid_tick_o) last_mid = n;
      if (bit_tick_o) begin
         if (last_bit >= 0) bit_gap = n - last_bit;
         if (last_mid >= 0) mid_bit = n - last_mid;
         last_bit = n;
      end
   endtask

   task automatic step();
      @(posedge clk);
      n++;
      model_edge();
      #1;
      check_outputs();
      track();
   endtask

   initial begin
      int k, e0, r;
      longint full;
      full     = (longint'(CLK_HZ) * FMOD) / (longint'(BAUD) * OVS);
      def_int  = int'(full / FMOD);
      def_frac = int'(full % FMOD);

      rst_i = 1'b0; en_i = 1'b0; cfg_valid_i = 1'b0; rx_resync_i = 1'b0;
      div_int_i = '0; div_frac_i = '0;
      model_reset();
      meas_reset();

      // Reset state
      repeat (3) step();
      chk("reset_ready", 32'(cfg_ready_o), 32'd1);
      rst_i = 1'b1;
      en_i  = 1'b1;

      // Default divisor: 54,54,54,55 oversample pattern, 868-cycle bits
      meas_reset();
      repeat (2700) step();
      chk("def_bit_gap", 32'(bit_gap), 32'd868);
      chk("def_mid_to_bit", 32'(mid_bit), 32'd434);
      chk("def_os_gap_min", 32'(os_gap_min), 32'd54);
      chk("def_os_gap_max", 32'(os_gap_max), 32'd55);

      // Illegal divisor rejected
      cfg_valid_i = 1'b1; div_int_i = 16'd1; div_frac_i = 4'd3;
      step();
      chk("err_pulse", 32'(cfg_err_o), 32'd1);
      chk("err_ready", 32'(cfg_ready_o), 32'd1);
      cfg_valid_i = 1'b0;
      step();
      chk("err_clear", 32'(cfg_err_o), 32'd0);
      meas_reset();
      repeat (1000) step();
      chk("err_os_gap_min", 32'(os_gap_min), 32'd54);
      chk("err_os_gap_max", 32'(os_gap_max), 32'd55);

      // Divisor 3.0 loaded while disabled
      en_i = 1'b0;
      repeat (2) step();
      cfg_valid_i = 1'b1; div_int_i = 16'd3; div_frac_i = 4'd0;
      step();
      chk("idle_ready_low", 32'(cfg_ready_o), 32'd0);
      cfg_valid_i = 1'b0;
      step();
      chk("idle_ready_back", 32'(cfg_ready_o), 32'd1);
      en_i = 1'b1;
      e0 = n + 1;
      k = 0;
      do begin step(); k++; end while (!os_tick_o && k < 50);
      chk("first_os_latency", 32'(n - e0), 32'd3);
      meas_reset();
      repeat (300) step();
      chk("div3_bit_gap", 32'(bit_gap), 32'd48);
      chk("div3_os_gap_max", 32'(os_gap_max), 32'd3);

      // Divisor change while running takes effect at the next tick
      step();
      cfg_valid_i = 1'b1; div_int_i = 16'd7; div_frac_i = 4'd0;
      step();
      chk("run_ready_low", 32'(cfg_ready_o), 32'd0);
      cfg_valid_i = 1'b0;
      k = 0;
      do begin step(); k++; end while (!cfg_ready_o && k < 20);
      chk("apply_at_tick", 32'(os_tick_o), 32'd1);
      meas_reset();
      repeat (150) step();
      chk("div7_os_gap_min", 32'(os_gap_min), 32'd7);
      chk("div7_os_gap_max", 32'(os_gap_max), 32'd7);

      // Resync on the edge a tick is due
      k = 0;
      while (m_next != n + 1 && k < 20) begin step(); k++; end
      rx_resync_i = 1'b1;
      step();
      chk("resync_no_tick", 32'(os_tick_o), 32'd0);
      chk("resync_cnt", 32'(os_cnt_o), 32'd0);
      rx_resync_i = 1'b0;
      r = n;
      k = 0;
      do begin step(); k++; end while (!mid_tick_o && k < 400);
      chk("resync_mid", 32'(n - r), 32'd56);

      // Random traffic
      repeat (3000) begin
         cfg_valid_i = ($urandom_range(0, 7) == 0);
         div_int_i   = DIV_W'($urandom_range(0, 9));
         div_frac_i  = FRAC_W'($urandom);
         rx_resync_i = ($urandom_range(0, 39) == 0);
         en_i        = ($urandom_range(0, 59) != 0);
         step();
      end

      // Reset mid-bit with a divisor pending
      cfg_valid_i = 1'b0; rx_resync_i = 1'b0; en_i = 1'b1;
      k = 0;
      while (!cfg_ready_o && k < 30) begin step(); k++; end
      cfg_valid_i = 1'b1; div_int_i = 16'd200; div_frac_i = 4'd0;
      step();
      chk("pend_ready_low", 32'(cfg_ready_o), 32'd0);
      cfg_valid_i = 1'b0;
      #3;
      rst_i = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("rst_async_ready", 32'(cfg_ready_o), 32'd1);
      chk("rst_async_os", 32'(os_tick_o), 32'd0);
      repeat (2) step();
      rst_i = 1'b1;
      meas_reset();
      repeat (2700) step();
      chk("post_rst_bit_gap", 32'(bit_gap), 32'd868);
      chk("post_rst_os_gap_max", 32'(os_gap_max), 32'd55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
